// File: rtl/mem_seq_pkg.sv
// Shared types for the strided memory sequencer: modes, pattern selects and FSM states.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        ModeFill  = 2'd0,
        ModeCheck = 2'd1,
        ModeCopy  = 2'd2,
        ModeNop   = 2'd3
    } mode_e;

    localparam logic [1:0] PAT_INV_IDX = 2'd0;
    localparam logic [1:0] PAT_INCR    = 2'd1;
    localparam logic [1:0] PAT_CONST   = 2'd2;
    localparam logic [1:0] PAT_WALK1   = 2'd3;

    typedef enum logic [1:0] {
        PatInvIdx = PAT_INV_IDX,
        PatIncr   = PAT_INCR,
        PatConst  = PAT_CONST,
        PatWalk1  = PAT_WALK1
    } pat_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StDone
    } state_e;

endpackage

// File: rtl/mem_seq_pattern.sv
// Combinational pattern generator: word for element index idx under the selected pattern.
module mem_seq_pattern
    import mem_seq_pkg::*;
#(
    parameter int unsigned MEM_DW   = 32,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic [CNT_BITS-1:0] idx,
    input  pat_e                sel,
    input  logic [MEM_DW-1:0]   seed,
    output logic [MEM_DW-1:0]   pat
);

    logic [MEM_DW-1:0]   idx_w;
    logic [CNT_BITS-1:0] walk_sh;

    always_comb begin
        idx_w   = MEM_DW'(idx);
        // Walking-one position uses the full index, not the truncated one.
        walk_sh = idx % CNT_BITS'(MEM_DW);
        pat     = '0;
        unique case (sel)
            PatInvIdx: pat = ~(idx_w + MEM_DW'(1));
            PatIncr:   pat = seed + idx_w;
            PatConst:  pat = seed;
            PatWalk1:  pat = MEM_DW'(1) << walk_sh;
            default:   pat = '0;
        endcase
    end

endmodule

// File: rtl/mem_seq_engine.sv
// Strided memory sequencer: FILL / CHECK / COPY over count elements on a single-port
// request bus, with a go/ret handshake towards the controller.
module mem_seq_engine
    import mem_seq_pkg::*;
#(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned MEM_DW   = 32,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned STR_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [1:0]          mode,
    input  logic [1:0]          pat_sel,
    input  logic [MEM_DW-1:0]   pat_seed,
    input  logic [MEM_AW-1:0]   src_base,
    input  logic [MEM_AW-1:0]   dst_base,
    input  logic [STR_BITS-1:0] src_stride,
    input  logic [STR_BITS-1:0] dst_stride,
    input  logic [CNT_BITS-1:0] count,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata,
    output logic                busy,
    output logic                ret,
    output logic [CNT_BITS-1:0] err_cnt,
    output logic [CNT_BITS-1:0] first_err_idx
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d, mode_in;
    pat_e                pat_sel_q, pat_sel_d;
    logic [MEM_DW-1:0]   seed_q, seed_d;
    logic [STR_BITS-1:0] src_stride_q, src_stride_d;
    logic [STR_BITS-1:0] dst_stride_q, dst_stride_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [CNT_BITS-1:0] idx_q, idx_d;
    logic [MEM_AW-1:0]   src_acc_q, src_acc_d;
    logic [MEM_AW-1:0]   dst_acc_q, dst_acc_d;
    logic [MEM_DW-1:0]   cap_q, cap_d;
    logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_BITS-1:0] first_err_q, first_err_d;
    logic [MEM_DW-1:0]   pat_w;
    logic                last;

    assign mode_in = mode_e'(mode);

    mem_seq_pattern #(
        .MEM_DW   (MEM_DW),
        .CNT_BITS (CNT_BITS)
    ) u_pattern (
        .idx  (idx_q),
        .sel  (pat_sel_q),
        .seed (seed_q),
        .pat  (pat_w)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pat_sel_d    = pat_sel_q;
        seed_d       = seed_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        count_d      = count_q;
        idx_d        = idx_q;
        src_acc_d    = src_acc_q;
        dst_acc_d    = dst_acc_q;
        cap_d        = cap_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        last         = (idx_q == count_q - CNT_BITS'(1));

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    mode_d       = mode_in;
                    pat_sel_d    = pat_e'(pat_sel);
                    seed_d       = pat_seed;
                    src_stride_d = src_stride;
                    dst_stride_d = dst_stride;
                    count_d      = count;
                    idx_d        = '0;
                    err_cnt_d    = '0;
                    first_err_d  = '1;
                    src_acc_d    = src_base;
                    dst_acc_d    = dst_base;
                    if (count == '0 || mode_in == ModeNop) begin
                        state_d = StDone;
                    end else if (mode_in == ModeFill) begin
                        state_d = StWrReq;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                mem_req  = 1'b1;
                mem_addr = src_acc_q;
                if (mem_gnt) begin
                    src_acc_d = src_acc_q + MEM_AW'(src_stride_q);
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (mem_rdata_vld) begin
                    if (mode_q == ModeCopy) begin
                        cap_d   = mem_rdata;
                        state_d = StWrReq;
                    end else begin
                        if (mem_rdata != pat_w) begin
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + CNT_BITS'(1);
                            end
                            if (first_err_q == '1) begin
                                first_err_d = idx_q;
                            end
                        end
                        idx_d   = idx_q + CNT_BITS'(1);
                        state_d = last ? StDone : StRdReq;
                    end
                end
            end
            StWrReq: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_acc_q;
                mem_wdata = (mode_q == ModeCopy) ? cap_q : pat_w;
                if (mem_gnt) begin
                    dst_acc_d = dst_acc_q + MEM_AW'(dst_stride_q);
                    idx_d     = idx_q + CNT_BITS'(1);
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        state_d = (mode_q == ModeCopy) ? StRdReq : StWrReq;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= ModeFill;
            pat_sel_q    <= PatInvIdx;
            seed_q       <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            src_acc_q    <= '0;
            dst_acc_q    <= '0;
            cap_q        <= '0;
            err_cnt_q    <= '0;
            first_err_q  <= '1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            pat_sel_q    <= pat_sel_d;
            seed_q       <= seed_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            src_acc_q    <= src_acc_d;
            dst_acc_q    <= dst_acc_d;
            cap_q        <= cap_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign ret           = (state_q == StDone);
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_mem_seq_engine.sv
// Scoreboard bench for mem_seq_engine: expected requests and ret results are queued by the
// stimulus, and a monitor pops and compares them as the DUT presents them.
module tb_mem_seq_engine;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } req_t;

    typedef struct {
        int          cyc;
        logic [15:0] err;
        logic [15:0] first;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  pat_sel = 2'd0;
    logic [31:0] pat_seed = '0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic [15:0] src_stride = '0;
    logic [15:0] dst_stride = '0;
    logic [15:0] count = '0;
    logic        mem_req;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b1;
    logic        mem_rdata_vld = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        ret;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;

    req_t        req_q[$];
    ret_t        ret_q[$];
    logic [31:0] src_mem [0:255];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ret_cnt = 0;
    int          rd_lat = 1;
    int          rd_cnt = 0;
    int          stall_left = 0;
    logic [15:0] stall_addr = '0;
    bit          rd_issue = 0;
    logic [15:0] rd_addr = '0;
    logic [31:0] rd_word = '0;
    bit          hold_pend = 0;
    logic        hold_wr = 1'b0;
    logic [15:0] hold_addr = '0;
    logic [31:0] hold_data = '0;

    mem_seq_engine u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .mode          (mode),
        .pat_sel       (pat_sel),
        .pat_seed      (pat_seed),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .src_stride    (src_stride),
        .dst_stride    (dst_stride),
        .count         (count),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rdata_vld (mem_rdata_vld),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .ret           (ret),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [31:0] d, input int c);
        req_q.push_back('{wr: 1'b1, addr: a, data: d, cyc: c});
    endtask

    task automatic exp_rd(input logic [15:0] a, input int c);
        req_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, cyc: c});
    endtask

    task automatic exp_ret(input int c, input logic [15:0] e, input logic [15:0] f);
        ret_q.push_back('{cyc: c, err: e, first: f});
    endtask

    // Samples at negedge; accepts pop the request scoreboard, ret pops the result one.
    task automatic monitor();
        req_t r;
        ret_t d;
        forever begin
            @(negedge clk);
            rd_issue = 0;
            if (hold_pend) begin
                chk("hold_req", 32'(mem_req), 32'h1);
                chk("hold_write", 32'(mem_write), 32'(hold_wr));
                chk("hold_addr", 32'(mem_addr), 32'(hold_addr));
                chk("hold_wdata", mem_wdata, hold_data);
            end
            if (mem_req && !mem_write) chk("rd_wdata_zero", mem_wdata, 32'h0);
            if (mem_req && mem_gnt) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    r = req_q.pop_front();
                    chk("req_write", 32'(mem_write), 32'(r.wr));
                    chk("req_addr", 32'(mem_addr), 32'(r.addr));
                    if (r.wr) chk("req_wdata", mem_wdata, r.data);
                    chk("req_cycle", 32'(cyc), 32'(r.cyc));
                end
                if (!mem_write) begin
                    rd_issue = 1;
                    rd_addr  = mem_addr;
                end
            end
            hold_pend = mem_req && !mem_gnt;
            hold_wr   = mem_write;
            hold_addr = mem_addr;
            hold_data = mem_wdata;
            if (ret) begin
                ret_cnt++;
                if (ret_q.size() == 0) begin
                    chk("unexpected_ret_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    d = ret_q.pop_front();
                    chk("ret_cycle", 32'(cyc), 32'(d.cyc));
                    chk("ret_err_cnt", 32'(err_cnt), 32'(d.err));
                    chk("ret_first_err", 32'(first_err_idx), 32'(d.first));
                    chk("ret_busy", 32'(busy), 32'h1);
                end
            end
        end
    endtask

    // Memory side: grant (with optional stall on one address) and read data after rd_lat cycles.
    task automatic responder();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (stall_left > 0 && mem_req && mem_addr == stall_addr) begin
                mem_gnt = 1'b0;
                stall_left--;
            end else begin
                mem_gnt = 1'b1;
            end
            if (rd_issue) begin
                rd_cnt  = rd_lat;
                rd_word = src_mem[rd_addr[7:0]];
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                mem_rdata_vld = (rd_cnt == 0);
                mem_rdata     = (rd_cnt == 0) ? rd_word : 32'h0;
            end else begin
                mem_rdata_vld = 1'b0;
                mem_rdata     = 32'h0;
            end
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [1:0] p, input logic [31:0] seed,
                         input logic [15:0] sb, input logic [15:0] ss, input logic [15:0] db,
                         input logic [15:0] ds, input logic [15:0] n, output int t);
        mode       = m;
        pat_sel    = p;
        pat_seed   = seed;
        src_base   = sb;
        src_stride = ss;
        dst_base   = db;
        dst_stride = ds;
        count      = n;
        go         = 1'b1;
        t          = cyc;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_ret();
        int seen = ret_cnt;
        for (int k = 0; k < 200 && ret_cnt == seen; k++) @(posedge clk);
        #1;
        chk("ret_arrived", 32'(ret_cnt != seen), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
        src_mem[8'h40] = 32'h10;
        src_mem[8'h42] = 32'h11;
        src_mem[8'h44] = 32'h0;
        src_mem[8'h46] = 32'h13;
        src_mem[8'h00] = 32'h1111_AAAA;
        src_mem[8'h02] = 32'h2222_BBBB;
        src_mem[8'h04] = 32'h3333_CCCC;
        fork
            monitor();
            responder();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ret", 32'(ret), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_first_err", 32'(first_err_idx), 32'hFFFF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FILL INV_IDX, 4 elements from 0x100.
        start(2'd0, 2'd0, 32'h0, 16'h0, 16'd0, 16'h100, 16'd1, 16'd4, t);
        exp_wr(16'h100, 32'hFFFF_FFFE, t + 1);
        exp_wr(16'h101, 32'hFFFF_FFFD, t + 2);
        exp_wr(16'h102, 32'hFFFF_FFFC, t + 3);
        exp_wr(16'h103, 32'hFFFF_FFFB, t + 4);
        exp_ret(t + 5, 16'h0, 16'hFFFF);
        wait_ret();

        // Same fill, element 1 denied for 3 cycles.
        stall_addr = 16'h101;
        stall_left = 3;
        start(2'd0, 2'd0, 32'h0, 16'h0, 16'd0, 16'h100, 16'd1, 16'd4, t);
        exp_wr(16'h100, 32'hFFFF_FFFE, t + 1);
        exp_wr(16'h101, 32'hFFFF_FFFD, t + 5);
        exp_wr(16'h102, 32'hFFFF_FFFC, t + 6);
        exp_wr(16'h103, 32'hFFFF_FFFB, t + 7);
        exp_ret(t + 8, 16'h0, 16'hFFFF);
        wait_ret();

        // CHECK INCR seed 0x10 at 0x40 stride 2; word at 0x44 is corrupt.
        rd_lat = 1;
        start(2'd1, 2'd1, 32'h10, 16'h40, 16'd2, 16'h0, 16'd0, 16'd4, t);
        exp_rd(16'h40, t + 1);
        exp_rd(16'h42, t + 3);
        exp_rd(16'h44, t + 5);
        exp_rd(16'h46, t + 7);
        exp_ret(t + 9, 16'd1, 16'd2);
        wait_ret();
        chk("err_cnt_hold", 32'(err_cnt), 32'd1);
        chk("first_err_hold", 32'(first_err_idx), 32'd2);

        // COPY 0x0/2 -> 0x200/3, read latency 2; a stray go mid-run must be ignored.
        rd_lat = 2;
        start(2'd2, 2'd2, 32'h0, 16'h0, 16'd2, 16'h200, 16'd3, 16'd3, t);
        exp_rd(16'h0, t + 1);
        exp_wr(16'h200, 32'h1111_AAAA, t + 4);
        exp_rd(16'h2, t + 5);
        exp_wr(16'h203, 32'h2222_BBBB, t + 8);
        exp_rd(16'h4, t + 9);
        exp_wr(16'h206, 32'h3333_CCCC, t + 12);
        exp_ret(t + 13, 16'h0, 16'hFFFF);
        @(posedge clk);
        #1;
        mode = 2'd0;
        go   = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_ret();

        // count == 0: ret one cycle after go, no requests.
        start(2'd0, 2'd0, 32'h0, 16'h0, 16'd0, 16'h300, 16'd1, 16'd0, t);
        exp_ret(t + 1, 16'h0, 16'hFFFF);
        wait_ret();

        // FILL WALK1 across the top of the address space.
        start(2'd0, 2'd3, 32'h0, 16'h0, 16'd0, 16'hFFFE, 16'd1, 16'd4, t);
        exp_wr(16'hFFFE, 32'h1, t + 1);
        exp_wr(16'hFFFF, 32'h2, t + 2);
        exp_wr(16'h0000, 32'h4, t + 3);
        exp_wr(16'h0001, 32'h8, t + 4);
        exp_ret(t + 5, 16'h0, 16'hFFFF);
        wait_ret();

        // Reset while a COPY read is outstanding; its late data must be ignored.
        rd_lat = 3;
        start(2'd2, 2'd2, 32'h0, 16'h0, 16'd2, 16'h300, 16'd1, 16'd2, t);
        exp_rd(16'h0, t + 1);
        @(posedge clk);
        #1;
        chk("rdwait_busy", 32'(busy), 32'h1);
        chk("rdwait_req", 32'(mem_req), 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req", 32'(mem_req), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_late_vld_busy", 32'(busy), 32'h0);
        chk("after_late_vld_req", 32'(mem_req), 32'h0);
        chk("after_late_vld_first_err", 32'(first_err_idx), 32'hFFFF);
        start(2'd0, 2'd2, 32'hCAFE_F00D, 16'h0, 16'd0, 16'h10, 16'd1, 16'd2, t);
        exp_wr(16'h10, 32'hCAFE_F00D, t + 1);
        exp_wr(16'h11, 32'hCAFE_F00D, t + 2);
        exp_ret(t + 3, 16'h0, 16'hFFFF);
        wait_ret();

        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        chk("ret_queue_drained", 32'(ret_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
